// File: rtl/control_unit.sv
// Multicycle RV64I controller: FETCH -> DECODE -> EXEC -> [MEM] -> WB, with HALT on
// illegal/SYSTEM opcodes and a wrapping retired-instruction counter.
module control_unit #(
    parameter int CNT_WIDTH    = 32,
    parameter int RESET_CYCLES = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [6:0]           opcode,
    output logic                 WE_RF,
    output logic                 WE_MEM,
    output logic [1:0]           RF_din_sel,
    output logic                 ULA_din2_sel,
    output logic                 load_pc,
    output logic                 reset_pc,
    output logic                 reset_ir,
    output logic                 pc_next_sel,
    output logic                 pc_adder_sel,
    output logic                 halted,
    output logic                 instr_retired,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic [2:0]           state
);

    localparam int RCW = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);

    localparam logic [6:0] OP_LOAD = 7'b0000011;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       din2;
        logic [1:0] rf_sel;
        logic       pc_next;
        logic       pc_adder;
        logic       we_rf;
        logic       we_mem;
    } ctrl_t;

    // Field order: legal, din2, rf_sel, pc_next, pc_adder, we_rf, we_mem.
    function automatic ctrl_t decode_op(input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            7'b0110011, 7'b0111011: c = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
            7'b0010011, 7'b0011011: c = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
            7'b0110111:             c = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
            7'b0000011:             c = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
            7'b0100011:             c = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
            7'b1100011:             c = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
            7'b1101111:             c = '{1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0};
            7'b1100111:             c = '{1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0};
            7'b0010111:             c = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0};
            default:                c = '0;
        endcase
        return c;
    endfunction

    state_t               state_q, state_d;
    logic [6:0]           op_q, op_d;
    logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rst_cnt_d = rst_cnt_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_RESET: begin
                if (rst_cnt_q <= RCW'(1)) state_d = S_FETCH;
                else                      rst_cnt_d = rst_cnt_q - RCW'(1);
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                op_d    = opcode;
                state_d = decode_op(opcode).legal ? S_EXEC : S_HALT;
            end
            // Only loads need the extra cycle for the data-memory read to settle.
            S_EXEC:   state_d = (op_q == OP_LOAD) ? S_MEM : S_WB;
            S_MEM:    state_d = S_WB;
            S_WB: begin
                cnt_d   = cnt_q + CNT_WIDTH'(1);
                state_d = S_FETCH;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_RESET;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_RESET;
            op_q      <= '0;
            rst_cnt_q <= RCW'(RESET_CYCLES);
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rst_cnt_q <= rst_cnt_d;
            cnt_q     <= cnt_d;
        end
    end

    ctrl_t ctl;
    logic  sel_en;
    logic  wb_en;

    // Selects hold from EXEC through WB; strobes fire only in WB and never on a reset edge.
    always_comb begin
        ctl    = decode_op(op_q);
        sel_en = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);
        wb_en  = (state_q == S_WB) && !RST;

        RF_din_sel    = sel_en ? ctl.rf_sel : 2'b00;
        ULA_din2_sel  = sel_en & ctl.din2;
        pc_next_sel   = sel_en & ctl.pc_next;
        pc_adder_sel  = sel_en & ctl.pc_adder;

        WE_RF         = wb_en & ctl.we_rf;
        WE_MEM        = wb_en & ctl.we_mem;
        load_pc       = wb_en;
        instr_retired = wb_en;

        reset_pc      = (state_q == S_RESET);
        reset_ir      = (state_q == S_RESET);
        halted        = (state_q == S_HALT);
        state         = state_q;
        retired_count = cnt_q;
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: WB expectations are queued per instruction and
// checked by a monitor whenever instr_retired is seen.
module tb_control_unit;

    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [6:0]    opcode = 7'd0;
    logic          WE_RF, WE_MEM, ULA_din2_sel, load_pc, reset_pc, reset_ir;
    logic          pc_next_sel, pc_adder_sel, halted, instr_retired;
    logic [1:0]    RF_din_sel;
    logic [CW-1:0] retired_count;
    logic [2:0]    state;

    control_unit #(.CNT_WIDTH(CW), .RESET_CYCLES(2)) dut (
        .CLK(CLK), .RST(RST), .opcode(opcode),
        .WE_RF(WE_RF), .WE_MEM(WE_MEM), .RF_din_sel(RF_din_sel),
        .ULA_din2_sel(ULA_din2_sel), .load_pc(load_pc), .reset_pc(reset_pc),
        .reset_ir(reset_ir), .pc_next_sel(pc_next_sel), .pc_adder_sel(pc_adder_sel),
        .halted(halted), .instr_retired(instr_retired),
        .retired_count(retired_count), .state(state)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [6:0] op;
        logic       din2;
        logic [1:0] rf;
        logic       pcn;
        logic       pca;
        logic       werf;
        logic       wemem;
    } vec_t;

    typedef struct packed {
        logic       din2;
        logic [1:0] rf;
        logic       pcn;
        logic       pca;
        logic       werf;
        logic       wemem;
        logic [CW-1:0] cnt;
    } exp_t;

    vec_t tbl [11];
    exp_t expq [$];
    int   checks = 0;
    int   errors = 0;
    logic [CW-1:0] exp_cnt = '0;
    bit   mon_en = 1'b0;

    initial begin
        tbl[0]  = '{7'b0110011, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{7'b0111011, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{7'b0010011, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{7'b0011011, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{7'b0110111, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{7'b0000011, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{7'b0100011, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{7'b1100011, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{7'b1101111, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{7'b1100111, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{7'b0010111, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: WB fields against the queue; outside a retirement no strobe may fire.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (instr_retired === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected actual=retire required=none");
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("wb_din2",     {31'd0, ULA_din2_sel}, {31'd0, e.din2});
                    chk("wb_rf_sel",   {30'd0, RF_din_sel},   {30'd0, e.rf});
                    chk("wb_pc_next",  {31'd0, pc_next_sel},  {31'd0, e.pcn});
                    chk("wb_pc_adder", {31'd0, pc_adder_sel}, {31'd0, e.pca});
                    chk("wb_we_rf",    {31'd0, WE_RF},        {31'd0, e.werf});
                    chk("wb_we_mem",   {31'd0, WE_MEM},       {31'd0, e.wemem});
                    chk("wb_load_pc",  {31'd0, load_pc},      32'd1);
                    chk("wb_count",    {{(32-CW){1'b0}}, retired_count}, {{(32-CW){1'b0}}, e.cnt});
                end
            end else begin
                chk("no_strobe", {29'd0, WE_RF, WE_MEM, load_pc}, 32'd0);
            end
        end
    end

    // Issue one instruction starting in FETCH and follow its state sequence.
    task automatic run_instr(input int idx);
        vec_t v;
        exp_t e;
        logic [2:0] seq [5];
        int n;
        v = tbl[idx];
        opcode = v.op;
        e = '{v.din2, v.rf, v.pcn, v.pca, v.werf, v.wemem, exp_cnt};
        expq.push_back(e);
        exp_cnt = exp_cnt + 1'b1;
        chk("start_fetch", {29'd0, state}, 32'd1);
        if (v.op == 7'b0000011) begin
            seq[0] = 3'd2; seq[1] = 3'd3; seq[2] = 3'd4; seq[3] = 3'd5; seq[4] = 3'd1; n = 5;
        end else begin
            seq[0] = 3'd2; seq[1] = 3'd3; seq[2] = 3'd5; seq[3] = 3'd1; seq[4] = 3'd1; n = 4;
        end
        for (int k = 0; k < n; k++) begin
            tick();
            chk($sformatf("seq_op%0h_step%0d", v.op, k), {29'd0, state}, {29'd0, seq[k]});
            if (seq[k] >= 3'd3 && seq[k] <= 3'd5) begin
                chk("sel_din2", {31'd0, ULA_din2_sel}, {31'd0, v.din2});
                chk("sel_rf",   {30'd0, RF_din_sel},   {30'd0, v.rf});
            end else begin
                chk("sel_idle", {27'd0, RF_din_sel, ULA_din2_sel, pc_next_sel, pc_adder_sel}, 32'd0);
            end
        end
    endtask

    task automatic do_reset(input int hold);
        RST = 1'b1;
        repeat (hold) tick();
        RST = 1'b0;
        exp_cnt = '0;
    endtask

    initial begin
        do_reset(3);
        mon_en = 1'b1;
        chk("rst_pc_c1", {30'd0, reset_pc, reset_ir}, 32'd3);
        chk("rst_state", {29'd0, state}, 32'd0);
        tick();
        chk("rst_pc_c2", {30'd0, reset_pc, reset_ir}, 32'd3);
        tick();
        chk("rst_pc_off", {30'd0, reset_pc, reset_ir}, 32'd0);
        chk("post_rst_state", {29'd0, state}, 32'd1);
        chk("post_rst_outs", {21'd0, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc,
                              pc_next_sel, pc_adder_sel, halted, instr_retired, 1'b0}, 32'd0);
        chk("post_rst_count", {{(32-CW){1'b0}}, retired_count}, 32'd0);

        for (int i = 0; i < 11; i++) run_instr(i);
        chk("count_after_11", {{(32-CW){1'b0}}, retired_count}, 32'd11);

        opcode = 7'b1110011;
        tick();
        chk("sys_decode", {29'd0, state}, 32'd2);
        tick();
        chk("sys_halt_state", {29'd0, state}, 32'd6);
        chk("sys_halted", {31'd0, halted}, 32'd1);
        opcode = 7'b0110011;
        repeat (100) tick();
        chk("halt_hold", {29'd0, state}, 32'd6);
        chk("halt_sels", {28'd0, RF_din_sel, ULA_din2_sel, pc_next_sel}, 32'd0);
        chk("halt_count", {{(32-CW){1'b0}}, retired_count}, 32'd11);

        do_reset(2);
        tick();
        tick();
        chk("restart_fetch", {29'd0, state}, 32'd1);
        chk("restart_halted", {31'd0, halted}, 32'd0);
        chk("restart_count", {{(32-CW){1'b0}}, retired_count}, 32'd0);

        opcode = 7'b0100011;
        begin
            int b;
            b = 0;
            while (state !== 3'd5 && b < 8) begin
                tick();
                b++;
            end
            chk("store_reach_wb", {29'd0, state}, 32'd5);
        end
        RST = 1'b1;
        #1;
        chk("rst_wb_we_mem", {31'd0, WE_MEM}, 32'd0);
        chk("rst_wb_load_pc", {31'd0, load_pc}, 32'd0);
        tick();
        tick();
        RST = 1'b0;
        exp_cnt = '0;
        tick();
        tick();
        chk("rst_wb_restart", {29'd0, state}, 32'd1);
        chk("rst_wb_count", {{(32-CW){1'b0}}, retired_count}, 32'd0);

        for (int i = 0; i < 16; i++) run_instr(i % 11);
        chk("count_wrap", {{(32-CW){1'b0}}, retired_count}, 32'd0);

        tick();
        chk("queue_empty", expq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
